// File: rtl/msx_clk_gen.sv
// MSX bus clock-enable, 1 ms tick and system reset generator.
// Runs entirely on the oscillator clock; every output comes straight from a flop.
module msx_clk_gen #(
  parameter int unsigned DIV        = 5,
  parameter int unsigned TICK_CE    = 3580,
  parameter int unsigned POR_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_rst_n,
  output logic ce_3m58,
  output logic msx_clk,
  output logic tick_1ms,
  output logic sys_rst
);

  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned TW = (TICK_CE > 1) ? $clog2(TICK_CE) : 1;
  localparam int unsigned CW = $clog2(POR_CYCLES + 1);
  localparam int unsigned H  = (DIV + 1) / 2;

  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] H_LAST = PW'(H - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TICK_CE - 1);
  localparam logic [CW-1:0] C_LAST = CW'(POR_CYCLES - 1);

  generate
    if (DIV < 2)        $error("msx_clk_gen: DIV must be >= 2");
    if (TICK_CE < 1)    $error("msx_clk_gen: TICK_CE must be >= 1");
    if (POR_CYCLES < 1) $error("msx_clk_gen: POR_CYCLES must be >= 1");
  endgenerate

  logic [PW-1:0] p_q, p_d;
  logic [TW-1:0] t_q, t_d;
  logic [CW-1:0] c_q, c_d;
  logic          ce_q, ce_d;
  logic          msx_q, msx_d;
  logic          tick_q, tick_d;
  logic          s1_q, s2_q;
  logic          srst_q, srst_d;

  // Phase and tick dividers: free-running, independent of the reset sequencer.
  // ce/tick/msx are computed one cycle early so the registered outputs land on the wrap edge.
  always_comb begin
    p_d    = (p_q == P_LAST) ? '0 : p_q + PW'(1);
    ce_d   = (p_q == P_LAST);
    // msx rises with ce and falls once phase H-1 has been held; it stays low until the first ce.
    msx_d  = ce_d | (msx_q & (p_q != H_LAST));
    tick_d = ce_d & (t_q == T_LAST);
    t_d    = t_q;
    if (ce_d) begin
      t_d = (t_q == T_LAST) ? '0 : t_q + TW'(1);
    end
  end

  // Reset sequencer: a synchronised-low button clears the hold counter and asserts sys_rst;
  // a steady high counts POR_CYCLES cycles before releasing it.
  always_comb begin
    c_d    = c_q;
    srst_d = srst_q;
    if (!s2_q) begin
      c_d    = '0;
      srst_d = 1'b1;
    end else if (srst_q) begin
      c_d = c_q + CW'(1);
      if (c_q == C_LAST) begin
        srst_d = 1'b0;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q    <= '0;
      t_q    <= '0;
      ce_q   <= 1'b0;
      msx_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      t_q    <= t_d;
      ce_q   <= ce_d;
      msx_q  <= msx_d;
      tick_q <= tick_d;
    end
  end

  // Button synchroniser and reset sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      c_q    <= '0;
      srst_q <= 1'b1;
    end else begin
      s1_q   <= btn_rst_n;
      s2_q   <= s1_q;
      c_q    <= c_d;
      srst_q <= srst_d;
    end
  end

  assign ce_3m58  = ce_q;
  assign msx_clk  = msx_q;
  assign tick_1ms = tick_q;
  assign sys_rst  = srst_q;

endmodule

// File: tb/tb_msx_clk_gen.sv
module tb_msx_clk_gen;

  localparam int unsigned A_DIV = 5;
  localparam int unsigned A_TCE = 3580;
  localparam int unsigned A_POR = 16;
  localparam int unsigned B_DIV = 2;
  localparam int unsigned B_TCE = 1;
  localparam int unsigned B_POR = 3;
  localparam int NCYC = 37000;

  typedef struct packed {
    logic ce;
    logic msx;
    logic tick;
    logic srst;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_rst_n = 1'b1;
  logic a_ce, a_msx, a_tick, a_srst;
  logic b_ce, b_msx, b_tick, b_srst;

  int total = 0;
  int bad = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Reference-model state: edges since reset release, and run lengths of
  // consecutive high button samples at edges n, n-1, n-2.
  int n = 0;
  int r0 = 0, r1 = 0, r2 = 0;
  int lowcnt = 0;
  bit did_rst = 0;

  always #5 clk = ~clk;

  msx_clk_gen #(.DIV(A_DIV), .TICK_CE(A_TCE), .POR_CYCLES(A_POR)) dut_a (
    .clk(clk), .rst(rst), .btn_rst_n(btn_rst_n),
    .ce_3m58(a_ce), .msx_clk(a_msx), .tick_1ms(a_tick), .sys_rst(a_srst)
  );

  msx_clk_gen #(.DIV(B_DIV), .TICK_CE(B_TCE), .POR_CYCLES(B_POR)) dut_b (
    .clk(clk), .rst(rst), .btn_rst_n(btn_rst_n),
    .ce_3m58(b_ce), .msx_clk(b_msx), .tick_1ms(b_tick), .sys_rst(b_srst)
  );

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Expected outputs after edge k since reset release.
  function automatic exp_t model(input int k, input int div, input int tce, input bit srst);
    exp_t e;
    e.ce   = (k > 0) && (k % div == 0);
    e.msx  = (k >= div) && ((k % div) < (div + 1) / 2);
    e.tick = e.ce && (((k / div) % tce) == 0);
    e.srst = srst;
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.ce = 1'b0; e.msx = 1'b0; e.tick = 1'b0; e.srst = 1'b1;
    return e;
  endfunction

  task automatic model_clear();
    n = 0; r0 = 0; r1 = 0; r2 = 0;
  endtask

  // One clock edge: update the model with the values the DUT just sampled and
  // push the expected response for this edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) begin
      qa.push_back(reset_exp());
      qb.push_back(reset_exp());
    end else begin
      n++;
      r2 = r1;
      r1 = r0;
      r0 = btn_rst_n ? r0 + 1 : 0;
      qa.push_back(model(n, A_DIV, A_TCE, !(r2 >= A_POR)));
      qb.push_back(model(n, B_DIV, B_TCE, !(r2 >= B_POR)));
    end
  endtask

  // Asynchronous reset mid-period; outputs must clear without a clock edge.
  task automatic async_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_ce_a", a_ce, 1'b0);
    check("async_msx_a", a_msx, 1'b0);
    check("async_tick_a", a_tick, 1'b0);
    check("async_srst_a", a_srst, 1'b1);
    check("async_ce_b", b_ce, 1'b0);
    check("async_msx_b", b_msx, 1'b0);
    check("async_tick_b", b_tick, 1'b0);
    check("async_srst_b", b_srst, 1'b1);
    qa.push_back(reset_exp());
    qb.push_back(reset_exp());
    model_clear();
    step();
    step();
    rst = 1'b0;
  endtask

  // Monitor: compare DUT outputs against queued expectations away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check("ce_a", a_ce, e.ce);
      check("msx_a", a_msx, e.msx);
      check("tick_a", a_tick, e.tick);
      check("srst_a", a_srst, e.srst);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check("ce_b", b_ce, e.ce);
      check("msx_b", b_msx, e.msx);
      check("tick_b", b_tick, e.tick);
      check("srst_b", b_srst, e.srst);
    end
  end

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("por_ce_a", a_ce, 1'b0);
    check("por_msx_a", a_msx, 1'b0);
    check("por_tick_a", a_tick, 1'b0);
    check("por_srst_a", a_srst, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < NCYC; i++) begin
      if (!did_rst && !rst && n == 502) begin
        did_rst = 1;
        async_reset();
      end else begin
        step();
      end
      if (lowcnt == 0) begin
        if (i == 60) lowcnt = 3;
        else if (i > 2000 && $urandom_range(0, 399) == 0) lowcnt = $urandom_range(1, 4);
      end
      if (lowcnt > 0) begin
        btn_rst_n = 1'b0;
        lowcnt--;
      end else begin
        btn_rst_n = 1'b1;
      end
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msx_clk_gen.md
Name: msx_clk_gen

Overview:
- Clock-enable and reset generator fed directly by the on-chip oscillator's ~17.9 MHz output (250 MHz / 14).
- Derives the 3.58 MHz MSX bus timing as a single-cycle clock enable plus a registered MSX CLK level, and a 1 ms housekeeping tick.
- Produces a synchronised, stretched system reset from the global reset and the board reset button.
- All downstream logic runs on the oscillator clock and qualifies its work with these enables. No derived clocks are used.

Parameters:
- DIV, 5: oscillator cycles per MSX clock period (17.9 MHz / 5 = 3.58 MHz); legal range ≥ 2.
- TICK_CE, 3580: ce_3m58 pulses per tick_1ms pulse; legal range ≥ 1.
- POR_CYCLES, 1024: oscillator cycles the button-synchronised release must persist before sys_rst drops; legal range ≥ 1.

Ports:
- clk  in  1  oscillator clock, ~17.9 MHz.
- rst  in  1  asynchronous active-high reset.
- btn_rst_n  in  1  asynchronous active-low reset button, unsynchronised.
- ce_3m58  out  1  one-cycle pulse every DIV clk cycles.
- msx_clk  out  1  registered MSX CLK level, period DIV, high for H = (DIV+1)/2 cycles (integer division).
- tick_1ms  out  1  one-cycle pulse coincident with every TICK_CE-th ce_3m58 pulse.
- sys_rst  out  1  active-high synchronous-release system reset.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. All flops clear asynchronously on rst and are otherwise clocked on the rising edge of clk.
- Reset values: ce_3m58 = 0, msx_clk = 0, tick_1ms = 0, sys_rst = 1.
  - Reset values of internal state: phase = 0, tick counter = 0, POR counter = 0, both synchroniser flops = 0.
- All outputs are driven directly from flops; no combinational path from any input to any output.
- Phase divider:
  - Counter p has width clog2(DIV); it increments every clk and wraps DIV-1 -> 0.
  - The first ce_3m58 pulse occurs on the DIV-th rising edge after rst deasserts, then every DIV edges thereafter, forever.
  - msx_clk rises on the same edge as each ce_3m58 pulse, stays high H cycles, then stays low DIV-H cycles.
  - msx_clk stays 0 until the first pulse.
  - With DIV = 5: high 3 cycles, low 2 cycles.
- Tick divider:
  - Counter width clog2(TICK_CE); it advances only on cycles where ce_3m58 is asserted.
  - tick_1ms asserts for exactly the cycle of the TICK_CE-th, 2·TICK_CE-th, ... ce_3m58 pulse after reset.
  - The counter wraps to 0 on that pulse.
  - With TICK_CE = 1, tick_1ms equals ce_3m58.
- Dividers run regardless of sys_rst and btn_rst_n, so bus clocks are present during system reset.
- Reset sequencer:
  - btn_rst_n passes through a 2-flop synchroniser (s1 -> s2), reset to 0 so that the button reads as pressed during reset.
  - Any cycle with s2 = 0: POR counter cleared and sys_rst = 1 on the next edge.
  - Cycles with s2 = 1 and sys_rst = 1: POR counter increments.
  - sys_rst falls on the edge where the counter would reach POR_CYCLES.
  - With btn_rst_n high throughout, sys_rst deasserts on rising edge POR_CYCLES + 2 after rst release; the 2 extra edges are the synchroniser latency.
  - Once sys_rst = 0, the POR counter holds and only an s2 = 0 cycle re-asserts sys_rst.
  - Re-assertion of sys_rst is synchronous, 2 edges after btn_rst_n falls (setup met).
  - Button pulses shorter than one clk period may be missed.
  - A pulse that reaches s2 restarts the full POR_CYCLES hold.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronous); sequencing restarts from edge 1 on release.
- Counter widths are sized so that no counter can overflow at legal parameter values. Parameters outside the legal ranges are rejected at elaboration.

Test Plan:
- Release rst at edge 0, default parameters -> ce_3m58 pulses at edges 5, 10, 15, ...; msx_clk high for edges 5-7, low for edges 8-9, and repeats with period 5.
- Run 3580·5·2 cycles -> tick_1ms pulses exactly at edges 17900 and 35800, each coincident with a ce_3m58 pulse; no other tick_1ms pulses.
- btn_rst_n held high, POR_CYCLES = 16 -> sys_rst = 1 through edge 17 and 0 from edge 18; ce_3m58 already toggling before edge 18.
- After sys_rst = 0, drive btn_rst_n low for 3 cycles -> sys_rst = 1 two edges after the fall; after btn_rst_n returns high, sys_rst falls POR_CYCLES + 2 edges later; ce_3m58 and msx_clk cadence undisturbed throughout.
- Assert rst asynchronously mid-period (phase 3, tick count 100) -> all outputs take reset values without a clock edge; after release, first ce_3m58 at edge 5 and first tick_1ms after a full TICK_CE ce_3m58 pulses.
- DIV = 2, TICK_CE = 1 -> ce_3m58 and tick_1ms both high every other cycle; msx_clk high 1 cycle, low 1 cycle.
